// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types and constants for the target-side controller
package i2c_pkg;

  typedef enum logic {
    I2C_MODE_WRITE = 1'b0,
    I2C_MODE_READ  = 1'b1
  } i2c_rw_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_slave_state_t;

  localparam int BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - 2-flop sync, glitch filter and edge strobes for one bus line
module i2c_line_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_f,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= 1'b1;
      sync1_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new level is accepted only after FILTER_CYCLES consecutive differing samples;
  // the strobe fires in the same cycle the filtered level changes.
  always_comb begin
    sync0_d = line_i;
    sync1_d = sync0_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync1_q != level_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        level_d = sync1_q;
        rise_d  = sync1_q;
        fall_d  = ~sync1_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign line_f = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target: START/STOP detect, 7-bit address match, byte shift with handshake
module i2c_slave
  import i2c_pkg::*;
#(
  parameter int       CLK_SYSTEM_FREQUENCY = 50000000,
  parameter bit [6:0] SLAVE_ADDR           = 7'h45,
  parameter int       FILTER_CYCLES        = 3
) (
  input  logic         clk,
  input  logic         rst,
  output i2c_rw_mode_t rw_mode,
  output logic [7:0]   write_data,
  output logic         rx_data_ready,
  input  logic [7:0]   read_data,
  output logic         tx_data_req,
  output logic         busy,
  output logic         stop_seen,
  inout  wire          sda_w,
  inout  wire          scl_w
);

  if (CLK_SYSTEM_FREQUENCY < 20 * 100000) begin : g_clk_too_slow
    $error("i2c_slave: clk must be at least 20x the SCL rate");
  end

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clk(clk), .rst(rst), .line_i(scl_w), .line_f(scl_f), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clk(clk), .rst(rst), .line_i(sda_w), .line_f(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_slave_state_t       state_q, state_d;
  logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   sda_oe_q, sda_oe_d;
  i2c_rw_mode_t           rw_q, rw_d;
  logic                   rx_rdy_q, rx_rdy_d;
  logic                   tx_req_q, tx_req_d;
  logic                   busy_q, busy_d;
  logic                   stop_q, stop_d;
  logic                   start_det, stop_det, sda_drive;
  logic [7:0]             new_byte;

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign new_byte  = {shift_q[6:0], sda_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      wdata_q  <= '0;
      sda_oe_q <= 1'b0;
      rw_q     <= I2C_MODE_WRITE;
      rx_rdy_q <= 1'b0;
      tx_req_q <= 1'b0;
      busy_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      wdata_q  <= wdata_d;
      sda_oe_q <= sda_oe_d;
      rw_q     <= rw_d;
      rx_rdy_q <= rx_rdy_d;
      tx_req_q <= tx_req_d;
      busy_q   <= busy_d;
      stop_q   <= stop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    wdata_d  = wdata_q;
    sda_oe_d = sda_oe_q;
    rw_d     = rw_q;
    busy_d   = busy_q;
    rx_rdy_d = 1'b0;
    tx_req_d = 1'b0;
    stop_d   = 1'b0;
    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = new_byte;
          cnt_d   = cnt_q + BIT_CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            if (new_byte[7:1] == SLAVE_ADDR) begin
              state_d = ST_ADDR_ACK;
              rw_d    = new_byte[0] ? I2C_MODE_READ : I2C_MODE_WRITE;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        // sda_oe_q doubles as the phase flag: first fall starts the ACK, second ends it.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q == I2C_MODE_READ) begin
              shift_d  = read_data;
              sda_oe_d = ~read_data[7];
              state_d  = ST_TX_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RX_BYTE;
            end
          end else if (scl_rise && sda_oe_q && rw_q == I2C_MODE_READ) begin
            tx_req_d = 1'b1;
          end
        end
        ST_RX_BYTE: if (scl_rise) begin
          shift_d = new_byte;
          cnt_d   = cnt_q + BIT_CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            wdata_d  = new_byte;
            rx_rdy_d = 1'b1;
            state_d  = ST_RX_ACK;
          end
        end
        ST_RX_ACK: if (scl_fall) begin
          sda_oe_d = ~sda_oe_q;
          cnt_d    = '0;
          if (sda_oe_q) state_d = ST_RX_BYTE;
        end
        ST_TX_BYTE: if (scl_fall) begin
          cnt_d = cnt_q + BIT_CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            sda_oe_d = 1'b0;
            state_d  = ST_TX_ACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              tx_req_d = 1'b1;
              cnt_d    = BIT_CNT_W'(1);
            end else begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && cnt_q == BIT_CNT_W'(1)) begin
            shift_d  = read_data;
            sda_oe_d = ~read_data[7];
            cnt_d    = '0;
            state_d  = ST_TX_BYTE;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  // Reset gates the driver combinationally so SDA lets go inside the reset cycle.
  always_comb begin
    sda_drive = sda_oe_q & ~rst;
  end

  assign sda_w         = sda_drive ? 1'b0 : 1'bz;
  assign scl_w         = 1'bz;
  assign rw_mode       = rw_q;
  assign write_data    = wdata_q;
  assign rx_data_ready = rx_rdy_q;
  assign tx_data_req   = tx_req_q;
  assign busy          = busy_q;
  assign stop_seen     = stop_q;

endmodule
